me_search_ctrl: RTL

ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

---
 rtl/me_search_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/me_search_ctrl.sv
// me_search_ctrl
//   Control FSM for a full-search block-matching motion estimator. It
//   sequences the PE array (clear, address counter enables) and follows the
//   scan position of the SADs streamed back. It keeps the minimum SAD and its
//   motion vector, and ends the search in one of three ways: the scan
//   completes, the best SAD drops below a threshold, or an abort arrives.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   req / ack       4-phase request/acknowledge handshake
//   early_term_en   enables the threshold early exit
//   threshold       early-exit threshold (compared against registered min)
//   abort           forces the search to end (honoured only in RUN)
//   sad_valid, sad  SAD stream from the PE array, one per scan position
//   clr             PE array clear pulse (CLEAR state)
//   en_addr_sw      search-window address counter enable
//   en_addr_tb      template address counter enable
//   en_pearray_tb   en_addr_tb delayed by one cycle
//   busy            high in CLEAR and RUN
//   min_sad         best SAD found
//   min_mvec        {y_off, x_off} of the best candidate
//   cand_cnt        number of candidates evaluated
//   early_term      search ended by threshold or abort
module me_search_ctrl #(
  parameter int SAD_WIDTH = 16,
  parameter int TB_LENGTH = 16,
  parameter int SW_LENGTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  output logic                       ack,
  input  logic                       early_term_en,
  input  logic [SAD_WIDTH-1:0]       threshold,
  input  logic                       abort,
  input  logic                       sad_valid,
  input  logic [SAD_WIDTH-1:0]       sad,
  output logic                       clr,
  output logic                       en_addr_sw,
  output logic                       en_addr_tb,
  output logic                       en_pearray_tb,
  output logic                       busy,
  output logic [SAD_WIDTH-1:0]       min_sad,
  output logic [2*$clog2(SW_LENGTH)-1:0] min_mvec,
  output logic [$clog2(SW_LENGTH*SW_LENGTH+1)-1:0] cand_cnt,
  output logic                       early_term
);

  localparam int VEC_WIDTH = $clog2(SW_LENGTH);
  localparam int NCAND     = (SW_LENGTH - TB_LENGTH + 1) * (SW_LENGTH - TB_LENGTH + 1);
  localparam int CNT_WIDTH = $clog2(SW_LENGTH * SW_LENGTH + 1);

  localparam logic [CNT_WIDTH-1:0] SW_SQ   = CNT_WIDTH'(SW_LENGTH * SW_LENGTH);
  localparam logic [CNT_WIDTH-1:0] TB_SQ   = CNT_WIDTH'(TB_LENGTH * TB_LENGTH);
  localparam logic [CNT_WIDTH-1:0] CAND_MX = CNT_WIDTH'(NCAND);
  localparam logic [VEC_WIDTH-1:0] SW_LAST = VEC_WIDTH'(SW_LENGTH - 1);
  localparam logic [VEC_WIDTH-1:0] TB_OFF  = VEC_WIDTH'(TB_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cyc;
  logic [VEC_WIDTH-1:0]   r_x;
  logic [VEC_WIDTH-1:0]   r_y;
  logic [SAD_WIDTH-1:0]   r_min_sad;
  logic [2*VEC_WIDTH-1:0] r_min_mvec;
  logic [CNT_WIDTH-1:0]   r_cand_cnt;
  logic                   r_early_term;
  logic                   r_en_pe;

  logic w_clr, w_ack, w_busy, w_en_sw, w_en_tb;
  logic w_scan_done, w_thr_hit, w_exit, w_is_cand;

  // The last scan position arriving ends the search in the same cycle; the
  // threshold looks at the registered minimum, so it fires one cycle after
  // the improving SAD was absorbed.
  assign w_scan_done = sad_valid && (r_x == SW_LAST) && (r_y == SW_LAST);
  assign w_thr_hit   = early_term_en && (r_min_sad < threshold);
  assign w_exit      = w_scan_done || w_thr_hit || abort;
  assign w_is_cand   = (r_x >= TB_OFF) && (r_y >= TB_OFF);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = req ? S_CLEAR : S_IDLE;
      S_CLEAR:  w_state_nxt = S_RUN;
      S_RUN:    w_state_nxt = w_exit ? S_FINISH : S_RUN;
      S_FINISH: w_state_nxt = req ? S_FINISH : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state and cycle counter registers
  always_comb begin
    w_clr   = 1'b0;
    w_ack   = 1'b0;
    w_busy  = 1'b0;
    w_en_sw = 1'b0;
    w_en_tb = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr  = 1'b1;
        w_busy = 1'b1;
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_en_sw = (r_cyc < SW_SQ);
        w_en_tb = (r_cyc < TB_SQ);
      end
      S_FINISH: w_ack = 1'b1;
      default:  w_ack = 1'b0;
    endcase
  end

  // Search datapath: scan position, best-match tracking, cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc        <= {CNT_WIDTH{1'b0}};
      r_x          <= {VEC_WIDTH{1'b0}};
      r_y          <= {VEC_WIDTH{1'b0}};
      r_min_sad    <= {SAD_WIDTH{1'b1}};
      r_min_mvec   <= {(2*VEC_WIDTH){1'b0}};
      r_cand_cnt   <= {CNT_WIDTH{1'b0}};
      r_early_term <= 1'b0;
      r_en_pe      <= 1'b0;
    end else begin
      r_en_pe <= w_en_tb;
      case (r_state)
        S_CLEAR: begin
          r_cyc        <= {CNT_WIDTH{1'b0}};
          r_x          <= {VEC_WIDTH{1'b0}};
          r_y          <= {VEC_WIDTH{1'b0}};
          r_min_sad    <= {SAD_WIDTH{1'b1}};
          r_min_mvec   <= {(2*VEC_WIDTH){1'b0}};
          r_cand_cnt   <= {CNT_WIDTH{1'b0}};
          r_early_term <= 1'b0;
        end
        S_RUN: begin
          // Saturate so the enables cannot re-assert on a long run
          if (r_cyc < SW_SQ) begin
            r_cyc <= r_cyc + CNT_WIDTH'(1);
          end
          if (sad_valid) begin
            if (r_y == SW_LAST) begin
              r_y <= {VEC_WIDTH{1'b0}};
              r_x <= (r_x == SW_LAST) ? {VEC_WIDTH{1'b0}} : r_x + VEC_WIDTH'(1);
            end else begin
              r_y <= r_y + VEC_WIDTH'(1);
            end
            if (w_is_cand && (r_cand_cnt < CAND_MX)) begin
              r_cand_cnt <= r_cand_cnt + CNT_WIDTH'(1);
              // Strict compare keeps the first of equal minima
              if (sad < r_min_sad) begin
                r_min_sad  <= sad;
                r_min_mvec <= {r_y - TB_OFF, r_x - TB_OFF};
              end
            end
          end
          // Scan completion takes precedence, so a coincident threshold or
          // abort still reports a normal finish.
          if (w_exit) begin
            r_early_term <= ~w_scan_done;
          end
        end
        default: r_cyc <= r_cyc;
      endcase
    end
  end

  assign clr           = w_clr;
  assign ack           = w_ack;
  assign busy          = w_busy;
  assign en_addr_sw    = w_en_sw;
  assign en_addr_tb    = w_en_tb;
  assign en_pearray_tb = r_en_pe;
  assign min_sad       = r_min_sad;
  assign min_mvec      = r_min_mvec;
  assign cand_cnt      = r_cand_cnt;
  assign early_term    = r_early_term;

endmodule
